sisc_fetch: RTL

Instruction fetch stage for the SISC processor. Holds the program counter, issues word reads to instruction memory, captures the returned word into an instruction register and presents it to the SISC datapath/control stage with a valid/ready handshake. Next-PC selection (sequential, relative branch, absolute branch) and halt detection live here. Redirect information comes back from the control unit.

---
 rtl/sisc_pkg.sv | 22 ++
 rtl/sisc_pc_next.sv | 34 +++
 rtl/sisc_fetch.sv | 104 ++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch stage: widths, opcode field layout
// and the fetch state encoding.
package sisc_pkg;

  localparam int PC_W_DEFAULT = 16;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  function automatic logic is_hlt(input logic [31:0] word);
    return word[OPC_HI:OPC_LO] == OP_HLT;
  endfunction

endpackage

// File: rtl/sisc_pc_next.sv
// Combinational next-PC selection: sequential, PC-relative or absolute branch,
// all wrapping modulo 2^PC_W.
module sisc_pc_next
  import sisc_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            br_taken_i,
  input  logic            br_rel_i,
  input  logic [15:0]     br_imm_i,
  output logic [PC_W-1:0] next_pc_o
);

  // Immediates widened to 32 bits so PC_W up to 32 can be sliced safely.
  logic [31:0]     imm_sext;
  logic [31:0]     imm_zext;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;

  assign imm_sext = {{16{br_imm_i[15]}}, br_imm_i};
  assign imm_zext = {16'h0000, br_imm_i};
  assign pc_inc   = pc_i + PC_W'(1);
  assign pc_rel   = pc_inc + imm_sext[PC_W-1:0];

  always_comb begin
    next_pc_o = pc_inc;
    if (br_taken_i) begin
      if (br_rel_i) next_pc_o = pc_rel;
      else          next_pc_o = imm_zext[PC_W-1:0];
    end
  end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch stage: PC register, instruction-memory request,
// instruction register with valid/ready handoff and halt detection.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int             PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  input  logic            instr_ready,
  input  logic            br_taken,
  input  logic            br_rel,
  input  logic [15:0]     br_imm,
  output logic [31:0]     instruction,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            req_q;
  logic            valid_q;
  logic            halted_q;

  logic            hlt_word;
  logic            br_taken_eff;
  logic [PC_W-1:0] next_pc_d;

  // A branch request riding on a HLT word is dropped.
  assign hlt_word     = is_hlt(instr_q);
  assign br_taken_eff = br_taken & ~hlt_word;

  sisc_pc_next #(
    .PC_W(PC_W)
  ) u_pc_next (
    .pc_i      (pc_q),
    .br_taken_i(br_taken_eff),
    .br_rel_i  (br_rel),
    .br_imm_i  (br_imm),
    .next_pc_o (next_pc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state_q <= HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc_q    <= next_pc_d;
            valid_q <= 1'b0;
            if (hlt_word) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule
